bit_serial_sub_ctrl: RTL
========================

// Module: bit_serial_sub_ctrl
// PURPOSE
//  Sequences one 1-bit full-subtractor cell (d = a^b^bin, b0 = ~a&b | ~(a^b)&bin) LSB-first
//  over WIDTH cycles to form an N-bit difference A - B - BIN.
//  Trades area for latency: one subtractor cell, shift registers and a borrow flop.
//  Sits between a requesting master (start/done handshake) and the subtractor datapath.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2)
// PORTS
//  clk         in   1      single system clock, rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  start       in   1      request; sampled only in IDLE
//  a           in   WIDTH  minuend, captured on accepted start
//  b           in   WIDTH  subtrahend, captured on accepted start
//  bin         in   1      initial borrow-in, captured on accepted start
//  busy        out  1      high while operation in progress (RUN state)
//  done        out  1      one-cycle pulse: diff/borrow_out valid
//  diff        out  WIDTH  result A-B-BIN mod 2^WIDTH; held until next completion
//  borrow_out  out  1      final borrow (1 => A < B+BIN unsigned); held with diff
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, busy=0, done=0, diff=0, borrow_out=0,
//   internal shift regs, borrow flop, bit counter all 0. Takes effect immediately, any state.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: on edge with start=1: a_sr<=a, b_sr<=b, br<=bin, cnt<=0, state<=RUN. start=0: stay.
//  RUN (busy=1): each edge: bit d/b0 from a_sr[0], b_sr[0], br;
//   d_sr <= {d, d_sr[WIDTH-1:1]}; a_sr,b_sr shift right; br<=b0; cnt<=cnt+1.
//   Edge where cnt==WIDTH-1: diff<={d, d_sr[WIDTH-1:1]}, borrow_out<=b0, state<=DONE.
//  DONE (done=1, busy=0): exactly one cycle, then IDLE unconditionally.
//  Latency: start accepted at edge 0 -> busy high after edges 1..WIDTH -> done high for the
//   cycle after edge WIDTH -> next start accepted at earliest edge WIDTH+2.
//  start during RUN or DONE: ignored, no queueing; a/b/bin changes during RUN ignored.
//  diff/borrow_out change only on the completing edge; stable otherwise (incl. during RUN).
//  Arithmetic: modulo 2^WIDTH; borrow_out is the carry-out of the WIDTH-th cell.
//  cnt width = clog2(WIDTH); no wrap beyond WIDTH-1 since RUN exits there.
//  Reset mid-RUN: operation abandoned, no done pulse, diff/borrow_out cleared to 0.
//  busy and done are registered (state decode), never high together.
// TESTING
//  WIDTH=8, a=0x5A b=0x3C bin=0, start 1 cycle -> done after 9 cycles, diff=0x1E, borrow_out=0.
//  a=0x00 b=0x01 bin=0 -> diff=0xFF, borrow_out=1; busy high exactly 8 cycles.
//  a=0x10 b=0x0F bin=1 -> diff=0x00, borrow_out=0; a=0x00 b=0x00 bin=1 -> diff=0xFF, borrow_out=1.
//  start held high continuously, a/b changed mid-RUN -> ops at cycles 0,10,20...; each result
//   matches operands at its accepting edge only.
//  rst_n low at RUN cycle 4 -> busy,done,diff,borrow_out=0 immediately; no done pulse; next op ok.
//  WIDTH=3 exhaustive a,b in 0..7, bin in 0..1 -> {borrow_out,diff} == (a-b-bin) mod 16 model.

Source files
------------

// File: rtl/bit_serial_sub_ctrl.sv
// Bit-serial subtractor controller: one full-subtractor cell stepped LSB-first
// over WIDTH cycles to form A - B - BIN, with a start/done handshake.
module bit_serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    // Only WIDTH-1 earlier bits need storing; the last bit goes straight into diff.
    logic [WIDTH-2:0] d_sr_q, d_sr_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic d_bit, b_bit;

    always_comb begin
        d_bit = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
        b_bit = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);

        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        d_sr_d   = d_sr_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                d_sr_d = (WIDTH-1)'({d_bit, d_sr_q} >> 1);
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                br_d   = b_bit;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    diff_d   = {d_bit, d_sr_q};
                    borrow_d = b_bit;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            d_sr_q   <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            d_sr_q   <= d_sr_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule
